// File: rtl/arb_multiplexer_pkg.sv
// Types shared by arb_multiplexer and its arbiter.
`include "mux_defs.vh"

package arb_multiplexer_pkg;

  // Arbitration mode as seen on the mode port.
  typedef enum logic {
    MODE_RR    = `MUX_MODE_RR,
    MODE_FIXED = `MUX_MODE_FIXED
  } mux_mode_e;

  // Reset value of the round-robin pointer: the last channel, so the first
  // circular search begins at channel 0.
  function automatic int ptr_reset_value(input int num_ch);
    return num_ch - 1;
  endfunction

endpackage

// File: rtl/mux_defs.vh
// Shared arbitration-mode encodings for the mux family of blocks.
`ifndef MUX_DEFS_VH
`define MUX_DEFS_VH

`define MUX_MODE_RR    1'b0
`define MUX_MODE_FIXED 1'b1

`endif

// File: rtl/rr_arbiter.sv
// Purely combinational circular-priority arbiter: grants the first requester
// found searching from ptr+1 up to and including ptr, wrapping at NUM_CH-1.
module rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any_grant
);

  // Walk the channels in rotated order and latch onto the first request.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant_idx  = SEL_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_multiplexer.sv
// N-to-1 arbitrated multiplexer with a single registered output stage.
// Round-robin or fixed-select arbitration; one transfer per cycle when the
// downstream side keeps dout_ready high.
module arb_multiplexer
  import arb_multiplexer_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] din,
  input  logic [NUM_CH-1:0]        din_valid,
  output logic [NUM_CH-1:0]        din_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        dout,
  output logic [SEL_W-1:0]         dout_ch,
  output logic                     dout_valid,
  input  logic                     dout_ready
);

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [NUM_CH-1:0] fixed_req;
  logic [NUM_CH-1:0] arb_req;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              any_grant;
  logic              load_en;

  logic [DATA_W-1:0] dout_reg,       dout_next;
  logic [SEL_W-1:0]  dout_ch_reg,    dout_ch_next;
  logic              dout_valid_reg, dout_valid_next;
  logic [SEL_W-1:0]  ptr_reg,        ptr_next;

  // Unpack the flattened bus and build the single-channel fixed-mode request.
  // An out-of-range sel matches no channel, so nothing is granted.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    assign ch_data[gi]   = din[gi*DATA_W +: DATA_W];
    assign fixed_req[gi] = din_valid[gi] & (int'(sel) == gi);
  end

  // Fixed mode reuses the round-robin arbiter with at most one request bit
  // set, so the grant is independent of ptr in that mode.
  assign arb_req = (mode == MODE_FIXED) ? fixed_req : din_valid;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arbiter (
    .req       (arb_req),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Output stage can take a word when empty or being drained this cycle.
  assign load_en   = !dout_valid_reg || dout_ready;
  assign din_ready = rst ? '0 : (grant & {NUM_CH{load_en}});

  // Next-state: load the granted word, or go empty (holding data) when no
  // channel is granted; hold everything while backpressured.
  always_comb begin
    dout_next       = dout_reg;
    dout_ch_next    = dout_ch_reg;
    dout_valid_next = dout_valid_reg;
    ptr_next        = ptr_reg;
    if (load_en) begin
      dout_valid_next = any_grant;
      if (any_grant) begin
        dout_next    = ch_data[grant_idx];
        dout_ch_next = grant_idx;
        ptr_next     = grant_idx;
      end
    end
  end

  // Output and pointer registers; reset drops any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg       <= '0;
      dout_ch_reg    <= '0;
      dout_valid_reg <= 1'b0;
      ptr_reg        <= SEL_W'(ptr_reset_value(NUM_CH));
    end else begin
      dout_reg       <= dout_next;
      dout_ch_reg    <= dout_ch_next;
      dout_valid_reg <= dout_valid_next;
      ptr_reg        <= ptr_next;
    end
  end

  assign dout       = dout_reg;
  assign dout_ch    = dout_ch_reg;
  assign dout_valid = dout_valid_reg;

endmodule

// File: tb/tb_arb_multiplexer.sv
// Self-checking bench for arb_multiplexer: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_arb_multiplexer;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH*DATA_W-1:0] din;
  logic [NUM_CH-1:0]        din_valid;
  logic [NUM_CH-1:0]        din_ready;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [DATA_W-1:0]        dout;
  logic [SEL_W-1:0]         dout_ch;
  logic                     dout_valid;
  logic                     dout_ready;

  always #5 clk = ~clk;

  arb_multiplexer #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .mode       (mode),
    .sel        (sel),
    .dout       (dout),
    .dout_ch    (dout_ch),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: contents of the output slot and last grant.
  logic [DATA_W-1:0] chan [NUM_CH];
  logic              m_valid = 1'b0;
  logic [DATA_W-1:0] m_dout  = '0;
  int                m_ch    = 0;
  int                m_ptr   = NUM_CH - 1;

  function automatic int model_grant();
    if (mode) begin
      if (int'(sel) < NUM_CH && din_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= NUM_CH; k++) begin
      if (din_valid[(m_ptr + k) % NUM_CH]) return (m_ptr + k) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_din();
    for (int i = 0; i < NUM_CH; i++) din[i*DATA_W +: DATA_W] = chan[i];
  endtask

  // One clock: check din_ready before the edge, update the model, then
  // check the output stage just after the edge.
  task automatic cycle();
    int g;
    logic load;
    logic [NUM_CH-1:0] er;
    drive_din();
    #1;
    g    = model_grant();
    load = !m_valid || dout_ready;
    er   = '0;
    if (!rst && load && g >= 0) er[g] = 1'b1;
    check("din_ready", 32'(din_ready), 32'(er));
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_dout = '0; m_ch = 0; m_ptr = NUM_CH - 1;
    end else if (load) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_dout = chan[g]; m_ch = g; m_ptr = g;
      end
    end
    #1;
    check("dout_valid", 32'(dout_valid), 32'(m_valid));
    check("dout", 32'(dout), 32'(m_dout));
    check("dout_ch", 32'(dout_ch), 32'(m_ch));
  endtask

  logic [DATA_W-1:0] rr_exp [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA};
  int                sp_exp [4] = '{2, 0, 2, 0};

  initial begin
    chan[0] = 8'hAA; chan[1] = 8'hBB; chan[2] = 8'hCC; chan[3] = 8'hDD;
    rst = 1'b1; din_valid = 4'b1111; mode = 1'b0; sel = '0; dout_ready = 1'b1;
    drive_din();

    // Reset held for two cycles with every channel requesting.
    cycle(); cycle();
    check("reset_valid", 32'(dout_valid), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);

    // Round-robin with all channels valid.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rr_seq_dout", 32'(dout), 32'(rr_exp[i]));
      check("rr_seq_ch", 32'(dout_ch), 32'(i % NUM_CH));
    end

    // Sparse requests on channels 0 and 2 starting from ptr=0.
    din_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rr_sparse_ch", 32'(dout_ch), 32'(sp_exp[i]));
    end

    // Backpressure while BB is held.
    din_valid = 4'b1111;
    cycle();
    check("bp_load", 32'(dout), 32'hBB);
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_hold", 32'(dout), 32'hBB);
    end
    dout_ready = 1'b1;
    cycle();
    check("bp_release", 32'(dout), 32'hCC);

    // Fixed-select mode, then change sel while the output is held.
    mode = 1'b1; sel = 2'd2;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("fixed_sel2", 32'(dout), 32'hCC);
    end
    dout_ready = 1'b0; sel = 2'd3;
    cycle(); cycle();
    check("fixed_held", 32'(dout), 32'hCC);
    dout_ready = 1'b1;
    cycle();
    check("fixed_sel3", 32'(dout), 32'hDD);

    // Reset while a word is held under backpressure.
    dout_ready = 1'b0; rst = 1'b1;
    cycle();
    check("midrst_valid", 32'(dout_valid), 32'd0);
    rst = 1'b0; mode = 1'b0; dout_ready = 1'b1;
    cycle();
    check("midrst_first", 32'(dout_ch), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_CH; i++) chan[i] = DATA_W'($urandom);
      din_valid  = NUM_CH'($urandom);
      mode       = ($urandom_range(0, 3) == 0);
      sel        = SEL_W'($urandom);
      dout_ready = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arb_multiplexer.md
ARB_MULTIPLEXER -- requirements
Module: arb_multiplexer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the channel data width in bits.
REQ-002 The block SHALL have parameter NUM_CH, default 4, legal range 2..16, giving the input channel count.
REQ-003 The block SHALL have derived constant SEL_W, equal to clog2(NUM_CH), giving the channel index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port din, input, NUM_CH*DATA_W bits: flattened channel data, with channel i at bits [i*DATA_W +: DATA_W].
REQ-007 The block SHALL have port din_valid, input, NUM_CH bits: per-channel valid.
REQ-008 The block SHALL have port din_ready, output, NUM_CH bits: per-channel ready, combinational.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 selects round-robin arbitration; 1 selects fixed-select arbitration.
REQ-010 The block SHALL have port sel, input, SEL_W bits: the channel used when mode=1.
REQ-011 The block SHALL have port dout, output, DATA_W bits: registered output data.
REQ-012 The block SHALL have port dout_ch, output, SEL_W bits: registered index of the source channel of dout.
REQ-013 The block SHALL have port dout_valid, output, 1 bit: registered output valid.
REQ-014 The block SHALL have port dout_ready, input, 1 bit: downstream ready.

Function
REQ-015 A channel transfer SHALL occur in a cycle where din_valid[i] and din_ready[i] are both high; an output transfer SHALL occur where dout_valid and dout_ready are both high.
REQ-016 load_en SHALL equal !dout_valid | dout_ready, so the output register accepts new data when empty or when it is being drained in the same cycle.
REQ-017 At most one din_ready bit SHALL be high in any cycle, namely grant[i] & load_en.
REQ-018 In mode=0, the grant SHALL go to the first channel with din_valid high, searching circularly from ptr+1 through ptr, where ptr is the last granted channel.
REQ-019 In mode=1, the grant SHALL go to channel sel only if din_valid[sel] is high; if sel >= NUM_CH, no channel SHALL be granted.
REQ-020 On a channel transfer, dout, dout_ch and dout_valid SHALL update at the next rising edge, giving a latency of 1 cycle; ptr SHALL update to the granted index in both modes.
REQ-021 With load_en high and no grant, dout_valid SHALL go to 0 at the next edge, and dout and dout_ch SHALL hold.
REQ-022 While dout_valid=1 and dout_ready=0, dout and dout_ch SHALL be held stable and all din_ready bits SHALL be 0.
REQ-023 Sustained throughput SHALL be 1 transfer per cycle when dout_ready is held high.
REQ-024 In mode=0 with all channels valid, grants SHALL rotate 0,1,...,NUM_CH-1,0,..., so no channel waits more than NUM_CH-1 grants.
REQ-025 A change to mode or sel SHALL affect only the next arbitration and SHALL never alter a held output.
REQ-026 When ptr = NUM_CH-1, the round-robin search SHALL wrap to channel 0.

Reset
REQ-027 While rst=1 at a rising edge, dout SHALL be set to 0, dout_ch to 0, dout_valid to 0, and ptr to NUM_CH-1, so the first round-robin search starts at channel 0.
REQ-028 While rst=1, din_ready SHALL be all 0.
REQ-029 A reset asserted mid-stream SHALL discard any held output word, with no transfer counted for it.

Structure
REQ-030 The mode encodings (MODE_RR=0, MODE_FIXED=1) SHALL live in the shared header mux_defs.vh, which all mux-family blocks include.
REQ-031 Arbitration SHALL be implemented in one sub-module, rr_arbiter (parameter NUM_CH; ports req, ptr, grant, grant_idx, any_grant), which is purely combinational.
REQ-032 The output register, ptr register and handshake logic SHALL reside in arb_multiplexer.
REQ-033 A competent implementation SHALL fit in 120-400 lines of RTL.

Verification
REQ-034 Reset: rst=1 for 2 cycles with all din_valid=1 -> dout_valid=0, dout=0, dout_ch=0, din_ready=0000.
REQ-035 RR full load: NUM_CH=4, DATA_W=8, din={8'hDD,8'hCC,8'hBB,8'hAA}, din_valid=1111, dout_ready=1 -> dout sequence AA,BB,CC,DD,AA with dout_ch 0,1,2,3,0 on consecutive cycles.
REQ-036 RR sparse: din_valid=0101 with ptr=0 -> grant ch2, then ch0, then ch2, alternating; ch1 and ch3 din_ready stay 0.
REQ-037 Backpressure: dout_ready=0 for 3 cycles while dout_valid=1, dout=BB -> dout and dout_ch stable and din_ready=0000 throughout; on dout_ready=1, the next word appears 1 cycle later.
REQ-038 Fixed mode: mode=1, sel=2, din_valid=1111 -> only ch2 is granted every cycle (dout=CC); switch to sel=3 -> the next loaded word is DD, and the held word is unaffected.
REQ-039 Mid-stream reset: assert rst while dout_valid=1 and dout_ready=0 -> dout_valid=0 at the next edge, and after release the first grant is ch0.
